// File: rtl/axis_slave_capture.sv
// AXI-Stream slave that captures one fixed-length burst into a word buffer,
// checks tlast framing, and exposes the buffer through a registered read port.
module axis_slave_capture #(
  parameter int data_width  = 32,
  parameter int trans_width = 4,
  parameter int trans_lenth = 2**trans_width
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [data_width-1:0]  s_data,
  input  logic                   s_valid,
  input  logic                   s_tlast,
  output logic                   s_ready,
  input  logic                   en,
  output logic                   done,
  output logic                   err_early,
  output logic                   err_late,
  output logic [trans_width:0]   word_cnt,
  input  logic [trans_width-1:0] rd_addr,
  output logic [data_width-1:0]  rd_data
);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  localparam logic [trans_width-1:0] LAST_IDX = trans_width'(trans_lenth - 1);

  state_t                  r_state;
  logic [trans_width-1:0]  r_cnt;
  logic                    r_ready;
  logic                    r_done;
  logic                    r_err_early;
  logic                    r_err_late;
  logic [trans_width:0]    r_word_cnt;
  logic [data_width-1:0]   r_rd_data;
  logic [data_width-1:0]   r_buf [trans_lenth];

  logic                    w_beat;
  logic                    w_last_idx;

  assign w_beat     = s_valid && r_ready;
  assign w_last_idx = (r_cnt == LAST_IDX);

  // Capture FSM, framing checks, buffer writes and registered read port
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_ready     <= 1'b0;
      r_done      <= 1'b0;
      r_err_early <= 1'b0;
      r_err_late  <= 1'b0;
      r_word_cnt  <= '0;
      r_rd_data   <= '0;
      for (int unsigned i = 0; i < trans_lenth; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      // Read samples the pre-edge buffer, so a same-index capture returns the old word
      r_rd_data <= r_buf[rd_addr];
      unique case (r_state)
        IDLE, DONE: begin
          if (en) begin
            r_state     <= RECV;
            r_ready     <= 1'b1;
            r_cnt       <= '0;
            r_word_cnt  <= '0;
            r_done      <= 1'b0;
            r_err_early <= 1'b0;
            r_err_late  <= 1'b0;
          end
        end
        RECV: begin
          if (w_beat) begin
            r_buf[r_cnt] <= s_data;
            r_cnt        <= r_cnt + 1'b1;
            r_word_cnt   <= r_word_cnt + 1'b1;
            // Dropping ready at the final-beat edge guarantees no surplus beat
            if (s_tlast || w_last_idx) begin
              r_ready     <= 1'b0;
              r_done      <= 1'b1;
              r_err_early <= s_tlast && !w_last_idx;
              r_err_late  <= !s_tlast && w_last_idx;
              r_state     <= DONE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_ready   = r_ready;
  assign done      = r_done;
  assign err_early = r_err_early;
  assign err_late  = r_err_late;
  assign word_cnt  = r_word_cnt;
  assign rd_data   = r_rd_data;

endmodule

// File: tb/tb_axis_slave_capture.sv
// Directed testbench for axis_slave_capture with hand-computed expectations.
module tb_axis_slave_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_tlast;
  logic        s_ready;
  logic        en;
  logic        done;
  logic        err_early;
  logic        err_late;
  logic [4:0]  word_cnt;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;

  int n_tests = 0;
  int n_fail  = 0;

  axis_slave_capture #(.data_width(32), .trans_width(4), .trans_lenth(16)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_tlast(s_tlast),
    .s_ready(s_ready), .en(en), .done(done), .err_early(err_early), .err_late(err_late),
    .word_cnt(word_cnt), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse en for one cycle; ready must be up and done clear right after the edge
  task automatic arm(input string tag);
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    check({tag, "_ready"}, s_ready, 1);
    check({tag, "_done"},  done, 0);
    check({tag, "_errs"},  {err_early, err_late}, 0);
    check({tag, "_wcnt"},  word_cnt, 0);
  endtask

  // Send n beats of base+i; tlast on beat tl_at (1-based, 0 = never); optional one-cycle gaps
  task automatic burst(input int base, input int n, input int tl_at, input bit gap);
    for (int i = 0; i < n; i++) begin
      int cyc;
      s_valid = 1'b1;
      s_data  = 32'(base + i);
      s_tlast = (i + 1 == tl_at);
      cyc = 0;
      while (!s_ready && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      if (cyc >= 100) check("beat_timeout", 0, 1);
      @(negedge clk);
      if (gap) begin
        s_valid = 1'b0;
        s_tlast = 1'b0;
        @(negedge clk);
      end
    end
    s_valid = 1'b0;
    s_tlast = 1'b0;
  endtask

  task automatic read_chk(input string tag, input int k, input int exp);
    rd_addr = 4'(k);
    @(negedge clk);
    check(tag, rd_data, 64'(exp));
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; s_valid = 1'b0; s_tlast = 1'b0; s_data = '0; rd_addr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check("rst_ready", s_ready, 0);
    check("rst_done",  done, 0);
    check("rst_errs",  {err_early, err_late}, 0);
    check("rst_wcnt",  word_cnt, 0);
    check("rst_rdata", rd_data, 0);

    // 1: back-to-back 0..15, tlast on beat 16
    arm("t1_arm");
    burst(0, 16, 16, 1'b0);
    check("t1_done",  done, 1);
    check("t1_ready", s_ready, 0);
    check("t1_wcnt",  word_cnt, 16);
    check("t1_early", err_early, 0);
    check("t1_late",  err_late, 0);
    for (int k = 0; k < 16; k++) read_chk("t1_buf", k, k);

    // 2: same burst with valid toggling
    arm("t2_arm");
    burst(0, 8, 0, 1'b1);
    check("t2_mid_done", done, 0);
    check("t2_mid_wcnt", word_cnt, 8);
    burst(8, 8, 8, 1'b1);
    check("t2_done", done, 1);
    check("t2_wcnt", word_cnt, 16);
    check("t2_errs", {err_early, err_late}, 0);
    for (int k = 0; k < 16; k += 5) read_chk("t2_buf", k, k);

    // 3: early tlast on beat 5
    arm("t3_arm");
    burst(0, 5, 5, 1'b0);
    check("t3_done",  done, 1);
    check("t3_ready", s_ready, 0);
    check("t3_wcnt",  word_cnt, 5);
    check("t3_early", err_early, 1);
    check("t3_late",  err_late, 0);
    read_chk("t3_buf4", 4, 4);
    read_chk("t3_buf5_old", 5, 5);

    // 4: 17 beats with no tlast; 17th must stay pending
    arm("t4_arm");
    burst(200, 16, 0, 1'b0);
    s_valid = 1'b1;
    s_data  = 32'd999;
    repeat (4) @(negedge clk);
    check("t4_ready", s_ready, 0);
    check("t4_wcnt",  word_cnt, 16);
    check("t4_late",  err_late, 1);
    check("t4_early", err_early, 0);
    s_valid = 1'b0;
    read_chk("t4_buf15", 15, 215);
    read_chk("t4_buf0", 0, 200);

    // 5: reset after 7 beats; a beat in the reset cycle is dropped
    arm("t5_arm");
    burst(50, 7, 0, 1'b0);
    rst = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'hDEAD;
    @(negedge clk);
    rst = 1'b1;
    s_valid = 1'b0;
    check("t5_ready", s_ready, 0);
    check("t5_done",  done, 0);
    check("t5_wcnt",  word_cnt, 0);
    check("t5_errs",  {err_early, err_late}, 0);
    read_chk("t5_buf3", 3, 0);
    read_chk("t5_buf7", 7, 0);
    arm("t5_rearm");
    burst(0, 16, 16, 1'b0);
    check("t5_done2", done, 1);
    check("t5_wcnt2", word_cnt, 16);
    check("t5_errs2", {err_early, err_late}, 0);
    read_chk("t5_buf9", 9, 9);

    // 6: re-arm from DONE, burst 100..115
    arm("t6_arm");
    burst(100, 16, 16, 1'b0);
    check("t6_done", done, 1);
    check("t6_wcnt", word_cnt, 16);
    check("t6_errs", {err_early, err_late}, 0);
    for (int k = 0; k < 16; k += 3) read_chk("t6_buf", k, 100 + k);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
